// File: rtl/vcb_pkg.sv
// Shared constants and helpers for the vcb counter family.
package vcb_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Default geometry used by the board top.
    localparam int unsigned     VCB_DEFAULT_W   = 4;
    localparam longint unsigned VCB_DEFAULT_MOD = 16;

    // Wide enough for W=32 with MOD=2^32.
    function automatic logic [32:0] vcb_clamp(input logic [32:0] value, input logic [32:0] mod_val);
        return (value < mod_val) ? value : (mod_val - 33'd1);
    endfunction

endpackage

// File: rtl/vcb_mod_counter.sv
// Parametrised modulo-MOD up/down counter with load, sticky overflow and TC/CEO cascade.
// Optional saturating mode: define VCB_MOD_COUNTER_SAT_EN.
module vcb_mod_counter
    import vcb_pkg::*;
#(
    parameter int unsigned     W   = VCB_DEFAULT_W,
    parameter longint unsigned MOD = VCB_DEFAULT_MOD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         R,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         TC,
    output logic         CEO,
    output logic         OVF
);

    generate
        if (W == 0 || W > 32 || MOD < 2 || MOD > (64'd1 << W)) begin : g_bad_param
            $error("vcb_mod_counter: illegal W/MOD combination");
        end
    endgenerate

    // Terminal value held one bit wider so MOD = 2^W is representable.
    localparam logic [W:0]   MOD_M1 = (W+1)'(MOD - 64'd1);
    localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] q_reg, q_next;
    logic         ovf_reg, ovf_next;
    logic         at_top, at_bottom;

    assign at_top    = ({1'b0, q_reg} == MOD_M1);
    assign at_bottom = (q_reg == '0);

    always_comb begin
        q_next   = q_reg;
        ovf_next = ovf_reg;
        if (R) begin
            q_next   = '0;
            ovf_next = 1'b0;
        end else if (load) begin
            q_next = W'(vcb_clamp(33'(D), 33'(MOD)));
        end else if (ce) begin
            if (up == DIR_UP) begin
                if (at_top) begin
`ifdef VCB_MOD_COUNTER_SAT_EN
                    q_next = q_reg;
`else
                    q_next = '0;
`endif
                    ovf_next = 1'b1;
                end else begin
                    q_next = q_reg + ONE;
                end
            end else begin
                if (at_bottom) begin
`ifdef VCB_MOD_COUNTER_SAT_EN
                    q_next = q_reg;
`else
                    q_next = MOD_M1[W-1:0];
`endif
                    ovf_next = 1'b1;
                end else begin
                    q_next = q_reg - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= '0;
            ovf_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            ovf_reg <= ovf_next;
        end
    end

    assign Q   = q_reg;
    assign OVF = ovf_reg;
    assign TC  = (up & at_top) | (~up & at_bottom);
    assign CEO = ce & TC;

endmodule
